// File: rtl/demux_sweep_ctrl_if.sv
// Handshake and channel bus between a word producer / channel consumers and demux_sweep_ctrl.
// The controller drives in_ready, sel, ch_data, ch_valid, busy and sweep_done.
interface demux_sweep_ctrl_if #(
  parameter int unsigned DW  = 4,
  parameter int unsigned NCH = 8
) ();
  logic                start;
  logic                mode;
  logic                stop;
  logic [DW-1:0]       in_data;
  logic [2:0]          in_sel;
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          sel;
  logic [DW*NCH-1:0]   ch_data;
  logic [NCH-1:0]      ch_valid;
  logic [NCH-1:0]      ch_ack;
  logic                busy;
  logic                sweep_done;

  modport master (
    output start, mode, stop, in_data, in_sel, in_valid, ch_ack,
    input  in_ready, sel, ch_data, ch_valid, busy, sweep_done
  );

  modport slave (
    input  start, mode, stop, in_data, in_sel, in_valid, ch_ack,
    output in_ready, sel, ch_data, ch_valid, busy, sweep_done
  );
endinterface

// File: rtl/demux_sweep_ctrl.sv
// Sequencing controller for the 1-to-8 demux: sweep or addressed routing into per-channel holding registers.
// Optional stall cycle counter output enabled by defining DEMUX_CTRL_STALL_CNT_EN.
module demux_sweep_ctrl #(
  parameter int unsigned DW  = 4,
  parameter int unsigned NCH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_sweep_ctrl_if.slave  bus
`ifdef DEMUX_CTRL_STALL_CNT_EN
  ,
  output logic [7:0]         stall_cnt
`endif
);

  localparam int unsigned SW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_ADDR  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       ptr_q, ptr_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [DW*NCH-1:0]   ch_data_q, ch_data_d;
  logic [NCH-1:0]      ch_valid_q, ch_valid_d;
  logic                sweep_done_q, sweep_done_d;

  logic [SW-1:0]       target_c;
  logic                in_ready_c;
  logic                wr_c;

  // Channel being offered the current word, and whether it can take it.
  always_comb begin
    target_c   = (state_q == S_ADDR) ? bus.in_sel : ptr_q;
    in_ready_c = (state_q != S_IDLE) &&
                 (!ch_valid_q[target_c] || bus.ch_ack[target_c]);
    // stop wins over a same-cycle accept in both active states
    wr_c       = bus.in_valid && in_ready_c && !bus.stop;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    ch_data_d    = ch_data_q;
    ch_valid_d   = ch_valid_q & ~bus.ch_ack;
    sweep_done_d = 1'b0;

    if (wr_c) begin
      sel_d = target_c;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (target_c == SW'(i)) begin
          ch_valid_d[i]          = 1'b1;
          ch_data_d[i*DW +: DW]  = bus.in_data;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ptr_d   = '0;
          state_d = bus.mode ? S_ADDR : S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (bus.stop) begin
          ptr_d   = '0;
          state_d = S_IDLE;
        end else if (wr_c) begin
          if (ptr_q == SW'(NCH - 1)) begin
            ptr_d        = '0;
            sweep_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            ptr_d = ptr_q + SW'(1);
          end
        end
      end
      S_ADDR: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.sel        = sel_q;
  assign bus.ch_data    = ch_data_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.sweep_done = sweep_done_q;

`ifdef DEMUX_CTRL_STALL_CNT_EN
  logic [CW-1:0] stall_q, stall_d;

  // Saturating count of cycles where an offered word is held off.
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && bus.start) begin
      stall_d = '0;
    end else if (state_q != S_IDLE && bus.in_valid && !in_ready_c &&
                 stall_q != {CW{1'b1}}) begin
      stall_d = stall_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/demux_sweep_ctrl.md
Name: demux_sweep_ctrl

Overview:
Sequencing controller for the 1-to-8 demux datapath. It accepts a stream of data words through a valid/ready handshake and drives the demux select. Each word lands in a per-channel holding register that the channel's consumer acknowledges. Two modes: an automatic sweep over channels 0..7, or addressed routing in which the requester supplies the channel per word.

Parameters:
DW, 4, data word width.
NCH, 8, number of output channels; fixed at 8 because the select is 3 bits.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
start  in  1  begin an operation; sampled only in S_IDLE.
mode  in  1  sampled with start: 0 = sweep, 1 = addressed.
stop  in  1  end addressed mode, or abort a sweep.
in_data  in  DW  data word.
in_sel  in  3  target channel in addressed mode; ignored in sweep mode.
in_valid  in  1  word present.
in_ready  out  1  controller can accept the word (combinational).
sel  out  3  registered demux select; the channel most recently written.
ch_data  out  DW*NCH  holding registers; channel i occupies bits [i*DW +: DW].
ch_valid  out  NCH  holding register i is full.
ch_ack  in  NCH  consumer i takes its word.
busy  out  1  state != S_IDLE.
sweep_done  out  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=S_IDLE, ptr=0, sel=0.
  - ch_data=0, ch_valid=0, sweep_done=0.
  - Reset mid-operation discards all pending words.
- target = (state==S_ADDR) ? in_sel : ptr.
- in_ready = (state!=S_IDLE) && (!ch_valid[target] || ch_ack[target]).
- accept = in_valid && in_ready. On accept, in the next cycle:
  - ch_data[target] = in_data, ch_valid[target] = 1, sel = target.
  - Latency is 1 clock.
- ch_ack[i] with no accept to channel i: ch_valid[i] clears the next cycle; ch_data[i] is held.
- ch_ack[i] with a simultaneous accept to channel i: ch_valid[i] stays 1 and takes the new data.
- ch_ack on an empty channel: no effect.
- Full target: in_ready=0; the word stalls until that channel is acked. Other channels are unaffected; there is no reordering.
- FSM:
  - S_IDLE:
    - start && !mode -> S_SWEEP, ptr=0.
    - start && mode -> S_ADDR.
    - stop is ignored.
  - S_SWEEP: each accept increments ptr.
    - Accept with ptr==7 -> ptr wraps to 0, sweep_done pulses the next cycle, -> S_IDLE.
    - stop (priority over accept in the same cycle) -> S_IDLE, ptr=0, no sweep_done, no write that cycle.
  - S_ADDR:
    - Accepts route by in_sel.
    - stop -> S_IDLE; a simultaneous accept is blocked.
    - ptr is unchanged.
- start, mode and stop outside the states above are ignored; mode is latched only at start.
- Holding registers keep their contents across state changes. ch_ack stays effective in S_IDLE.
- sel holds its value between accepts and in S_IDLE.

Optional Feature:
Macro: DEMUX_CTRL_STALL_CNT_EN.
- Defined:
  - Extra output port stall_cnt, 8 bits.
  - Counts cycles with state!=S_IDLE && in_valid && !in_ready; saturates at 255.
  - Cleared by reset and by start accepted in S_IDLE.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start=1, mode=0, in_data=4'b1011 held valid, ch_ack=0:
  - sel steps 0..7 over 8 consecutive cycles.
  - ch_valid=8'hFF and every ch_data slice = 4'b1011.
  - sweep_done pulses once; busy falls.
- Same sweep with ch_valid[3] already full (from a prior addressed write) and ch_ack[3] raised at cycle 10:
  - in_ready is 0 from ptr=3 until ack.
  - The word is written to channel 3 the cycle after ack; ch_valid[3] never drops.
- start, mode=1; words 4'h1, 4'h2, 4'h3 with in_sel 5, 0, 5; ch_ack[5] asserted with the third word:
  - ch_data[5]=4'h3 and ch_data[0]=4'h2; sel sequence 5, 0, 5.
  - stop -> busy=0.
- Sweep aborted by stop after 3 accepts:
  - No sweep_done.
  - Channels 0..2 valid, 3..7 empty.
  - A new sweep restarts at channel 0.
- rst_n low for one cycle mid-sweep (ptr=4): all outputs return to reset values the next cycle; in_ready=0.
- With DEMUX_CTRL_STALL_CNT_EN: channel 0 kept full, 300 cycles of stall -> stall_cnt=255; a new start clears it to 0.
